// File: rtl/mycpu_axi_pkg.sv
// mycpu_axi_pkg: AXI4 constants and FSM state encodings shared by the CPU AXI bridge.
package mycpu_axi_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         ID_INST    = 0;
  localparam int         ID_DATA    = 1;
  localparam logic [2:0] PROT_INST  = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW_W, W_B} wr_state_e;
endpackage

// File: rtl/cpu_axi_wr_chan.sv
// cpu_axi_wr_chan: AW/W/B sequencing for one single-beat write, AW and W accepted independently.
module cpu_axi_wr_chan
  import mycpu_axi_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic aw_ready,
  input  logic w_ready,
  input  logic b_valid,
  output logic aw_valid,
  output logic w_valid,
  output logic b_ready,
  output logic idle,
  output logic done
);
  wr_state_e state_q, state_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, aw_ok, w_ok;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
  // Flags only matter while waiting in W_AW_W; they clear once both sides are in.
  always_comb begin
    aw_ok     = aw_done_q | (aw_valid & aw_ready);
    w_ok      = w_done_q | (w_valid & w_ready);
    state_d   = state_q;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    case (state_q)
      W_IDLE: state_d = start ? W_AW_W : W_IDLE;
      W_AW_W: begin
        state_d   = (aw_ok & w_ok) ? W_B : W_AW_W;
        aw_done_d = aw_ok & ~w_ok;
        w_done_d  = w_ok & ~aw_ok;
      end
      W_B:     state_d = b_valid ? W_IDLE : W_B;
      default: state_d = W_IDLE;
    endcase
  end
  always_comb begin
    aw_valid = (state_q == W_AW_W) & ~aw_done_q;
    w_valid  = (state_q == W_AW_W) & ~w_done_q;
    b_ready  = state_q == W_B;
    idle     = state_q == W_IDLE;
    done     = b_ready & b_valid;
  end
endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: inst/data sram ports to one single-beat AXI4 master, data first, never overlapped.
// Define CPU_AXI_BUS_ERR_EN to record non-OKAY responses in sticky bus_err/bus_err_addr.
module cpu_axi_bridge
  import mycpu_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        inst_sram_en,
  input  logic [7:0]                  inst_sram_we,
  input  logic [63:0]                 inst_sram_addr,
  input  logic [63:0]                 inst_sram_wdata,
  output logic [63:0]                 inst_sram_rdata,
  input  logic                        data_sram_en,
  input  logic [7:0]                  data_sram_we,
  input  logic [63:0]                 data_sram_addr,
  input  logic [63:0]                 data_sram_wdata,
  output logic [63:0]                 data_sram_rdata,
  output logic                        stallreq_axi,
  output logic [AXI_ID_WIDTH-1:0]     core_axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   core_axi_aw_addr,
  output logic [7:0]                  core_axi_aw_len,
  output logic [2:0]                  core_axi_aw_size,
  output logic [1:0]                  core_axi_aw_burst,
  output logic                        core_axi_aw_lock,
  output logic [3:0]                  core_axi_aw_cache,
  output logic [2:0]                  core_axi_aw_prot,
  output logic [3:0]                  core_axi_aw_qos,
  output logic [3:0]                  core_axi_aw_region,
  output logic [AXI_USER_WIDTH-1:0]   core_axi_aw_user,
  output logic                        core_axi_aw_valid,
  input  logic                        core_axi_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   core_axi_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] core_axi_w_strb,
  output logic                        core_axi_w_last,
  output logic [AXI_USER_WIDTH-1:0]   core_axi_w_user,
  output logic                        core_axi_w_valid,
  input  logic                        core_axi_w_ready,
  input  logic [AXI_ID_WIDTH-1:0]     core_axi_b_id,
  input  logic [1:0]                  core_axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0]   core_axi_b_user,
  input  logic                        core_axi_b_valid,
  output logic                        core_axi_b_ready,
  output logic [AXI_ID_WIDTH-1:0]     core_axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   core_axi_ar_addr,
  output logic [7:0]                  core_axi_ar_len,
  output logic [2:0]                  core_axi_ar_size,
  output logic [1:0]                  core_axi_ar_burst,
  output logic                        core_axi_ar_lock,
  output logic [3:0]                  core_axi_ar_cache,
  output logic [2:0]                  core_axi_ar_prot,
  output logic [3:0]                  core_axi_ar_qos,
  output logic [3:0]                  core_axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0]   core_axi_ar_user,
  output logic                        core_axi_ar_valid,
  input  logic                        core_axi_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]     core_axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   core_axi_r_data,
  input  logic [1:0]                  core_axi_r_resp,
  input  logic                        core_axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0]   core_axi_r_user,
  input  logic                        core_axi_r_valid,
  output logic                        core_axi_r_ready,
  output logic                        bus_err,
  output logic [63:0]                 bus_err_addr
);
  rd_state_e r_state_q, r_state_d;
  logic rd_inst_q, rd_inst_d, inst_done_q, inst_done_d, data_done_q, data_done_d;
  logic [63:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d, sel_addr;
  logic idle, wr_idle, wr_done, sel_data, sel_inst, start_rd, start_wr, r_hs, unused_sig;
  assign stallreq_axi = (inst_sram_en & ~inst_done_q) | (data_sram_en & ~data_done_q);
  // A new transaction is only picked when both channels are quiet, data before fetch.
  always_comb begin
    idle     = (r_state_q == R_IDLE) & wr_idle;
    sel_data = idle & data_sram_en & ~data_done_q;
    sel_inst = idle & ~sel_data & inst_sram_en & ~inst_done_q;
    start_wr = sel_data & (|data_sram_we);
    start_rd = sel_inst | (sel_data & ~(|data_sram_we));
    r_hs     = core_axi_r_valid & core_axi_r_ready;
    sel_addr = rd_inst_q ? inst_sram_addr : data_sram_addr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q    <= R_IDLE;
      rd_inst_q    <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      r_state_q    <= r_state_d;
      rd_inst_q    <= rd_inst_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end
  always_comb begin
    r_state_d = r_state_q;
    rd_inst_d = rd_inst_q;
    case (r_state_q)
      R_IDLE: if (start_rd) begin
        r_state_d = R_AR;
        rd_inst_d = sel_inst;
      end
      R_AR:    r_state_d = core_axi_ar_ready ? R_WAIT : R_AR;
      R_WAIT:  r_state_d = core_axi_r_valid ? R_IDLE : R_WAIT;
      default: r_state_d = R_IDLE;
    endcase
  end
  always_comb begin
    core_axi_ar_valid = r_state_q == R_AR;
    core_axi_r_ready  = r_state_q == R_WAIT;
  end
  // Done flags survive until the pipeline advances (the one cycle stall is low).
  always_comb begin
    inst_rdata_d = (r_hs & rd_inst_q) ? core_axi_r_data : inst_rdata_q;
    data_rdata_d = (r_hs & ~rd_inst_q) ? core_axi_r_data : data_rdata_q;
    inst_done_d  = stallreq_axi & (inst_done_q | (r_hs & rd_inst_q));
    data_done_d  = stallreq_axi & (data_done_q | (r_hs & ~rd_inst_q) | wr_done);
  end
  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;
  cpu_axi_wr_chan u_wr (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_wr),
    .aw_ready (core_axi_aw_ready),
    .w_ready  (core_axi_w_ready),
    .b_valid  (core_axi_b_valid),
    .aw_valid (core_axi_aw_valid),
    .w_valid  (core_axi_w_valid),
    .b_ready  (core_axi_b_ready),
    .idle     (wr_idle),
    .done     (wr_done)
  );
  assign core_axi_aw_id     = AXI_ID_WIDTH'(ID_DATA);
  assign core_axi_aw_addr   = {data_sram_addr[AXI_ADDR_WIDTH-1:3], 3'b000};
  assign core_axi_aw_len    = 8'd0;
  assign core_axi_aw_size   = SIZE_8B;
  assign core_axi_aw_burst  = BURST_INCR;
  assign core_axi_aw_lock   = 1'b0;
  assign core_axi_aw_cache  = 4'd0;
  assign core_axi_aw_prot   = PROT_DATA;
  assign core_axi_aw_qos    = 4'd0;
  assign core_axi_aw_region = 4'd0;
  assign core_axi_aw_user   = '0;
  assign core_axi_w_data    = data_sram_wdata;
  assign core_axi_w_strb    = data_sram_we;
  assign core_axi_w_last    = 1'b1;
  assign core_axi_w_user    = '0;
  assign core_axi_ar_id     = rd_inst_q ? AXI_ID_WIDTH'(ID_INST) : AXI_ID_WIDTH'(ID_DATA);
  assign core_axi_ar_addr   = {sel_addr[AXI_ADDR_WIDTH-1:3], 3'b000};
  assign core_axi_ar_len    = 8'd0;
  assign core_axi_ar_size   = SIZE_8B;
  assign core_axi_ar_burst  = BURST_INCR;
  assign core_axi_ar_lock   = 1'b0;
  assign core_axi_ar_cache  = 4'd0;
  assign core_axi_ar_prot   = rd_inst_q ? PROT_INST : PROT_DATA;
  assign core_axi_ar_qos    = 4'd0;
  assign core_axi_ar_region = 4'd0;
  assign core_axi_ar_user   = '0;
`ifdef CPU_AXI_BUS_ERR_EN
  logic bus_err_q, bus_err_d, rd_err, wr_err;
  logic [63:0] bus_err_addr_q, bus_err_addr_d;
  always_comb begin
    rd_err         = r_hs & (core_axi_r_resp != RESP_OKAY);
    wr_err         = wr_done & (core_axi_b_resp != RESP_OKAY);
    bus_err_d      = bus_err_q | rd_err | wr_err;
    bus_err_addr_d = rd_err ? sel_addr : wr_err ? data_sram_addr : bus_err_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_q      <= 1'b0;
      bus_err_addr_q <= '0;
    end else begin
      bus_err_q      <= bus_err_d;
      bus_err_addr_q <= bus_err_addr_d;
    end
  end
  assign bus_err      = bus_err_q;
  assign bus_err_addr = bus_err_addr_q;
`else
  assign bus_err      = 1'b0;
  assign bus_err_addr = '0;
`endif
  assign unused_sig = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr, data_sram_addr, core_axi_r_id,
                        core_axi_r_last, core_axi_r_user, core_axi_b_id, core_axi_b_user,
                        core_axi_r_resp, core_axi_b_resp};
endmodule
